// File: rtl/fewcore_pkg.sv
// Shared types and constants for the in-order core's issue-side helpers.
// Slot records are sized for up to 32 architectural registers.
package fewcore_pkg;

   localparam int unsigned XlenDefault = 32;
   localparam int unsigned RegAddrW    = 5;
   localparam int unsigned SEL_REGFILE = 0;

   typedef struct packed {
      logic                valid;
      logic [RegAddrW-1:0] rd;
      logic                wr;
      logic                is_load;
   } slot_t;

endpackage

// File: rtl/sb_lookup.sv
// One-operand priority match over the in-flight slots: youngest matching writer wins,
// flagging a hazard when that writer's result is not yet available.
module sb_lookup
   import fewcore_pkg::*;
#(
   parameter int unsigned XLEN     = XlenDefault,
   parameter int unsigned STAGES   = 3,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned SW       = $clog2(STAGES + 1)
) (
   input  logic [RegAddrW-1:0]    rs_i,
   input  slot_t [STAGES-1:0]     slots_i,
   input  logic [STAGES*XLEN-1:0] stage_data_i,
   output logic [SW-1:0]          sel_o,
   output logic [XLEN-1:0]        data_o,
   output logic                   hazard_o
);

   logic found;

   always_comb begin
      sel_o    = SW'(SEL_REGFILE);
      data_o   = '0;
      hazard_o = 1'b0;
      found    = 1'b0;
      // x0 is hardwired, so it never matches an in-flight writer.
      if (rs_i != '0) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            if (!found && slots_i[k].valid && slots_i[k].wr && (slots_i[k].rd == rs_i)) begin
               found = 1'b1;
               if (!slots_i[k].is_load || (k >= LOAD_LAT)) begin
                  sel_o  = SW'(k + 1);
                  data_o = stage_data_i[k*XLEN +: XLEN];
               end else begin
                  hazard_o = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/scoreboard_fwd.sv
// In-flight register scoreboard: tracks STAGES slots between issue and writeback,
// produces per-operand forwarding and the load-use stall.
module scoreboard_fwd
   import fewcore_pkg::*;
#(
   parameter  int unsigned XLEN     = XlenDefault,
   parameter  int unsigned NREG     = 32,
   parameter  int unsigned STAGES   = 3,
   parameter  int unsigned LOAD_LAT = 1,
   localparam int unsigned RA       = $clog2(NREG),
   localparam int unsigned SW       = $clog2(STAGES + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   issue_valid,
   input  logic [RA-1:0]          issue_rs1,
   input  logic [RA-1:0]          issue_rs2,
   input  logic [RA-1:0]          issue_rd,
   input  logic                   issue_wr,
   input  logic                   issue_is_load,
   input  logic                   flush,
   input  logic [STAGES*XLEN-1:0] stage_data,
   output logic                   stall,
   output logic [SW-1:0]          fwd_sel_rs1,
   output logic [SW-1:0]          fwd_sel_rs2,
   output logic [XLEN-1:0]        fwd_data_rs1,
   output logic [XLEN-1:0]        fwd_data_rs2,
   output logic [SW-1:0]          inflight,
   output logic [31:0]            stall_count
);

   slot_t [STAGES-1:0] slots_q, slots_d;
   logic [SW-1:0]      inflight_q, inflight_d;
   logic [31:0]        stall_count_q, stall_count_d;
   logic               hazard_rs1, hazard_rs2;

   sb_lookup #(
      .XLEN     (XLEN),
      .STAGES   (STAGES),
      .LOAD_LAT (LOAD_LAT),
      .SW       (SW)
   ) u_lookup_rs1 (
      .rs_i         (RegAddrW'(issue_rs1)),
      .slots_i      (slots_q),
      .stage_data_i (stage_data),
      .sel_o        (fwd_sel_rs1),
      .data_o       (fwd_data_rs1),
      .hazard_o     (hazard_rs1)
   );

   sb_lookup #(
      .XLEN     (XLEN),
      .STAGES   (STAGES),
      .LOAD_LAT (LOAD_LAT),
      .SW       (SW)
   ) u_lookup_rs2 (
      .rs_i         (RegAddrW'(issue_rs2)),
      .slots_i      (slots_q),
      .stage_data_i (stage_data),
      .sel_o        (fwd_sel_rs2),
      .data_o       (fwd_data_rs2),
      .hazard_o     (hazard_rs2)
   );

   // A flushed instruction is squashed anyway, so it must never hold the front end.
   assign stall = issue_valid & ~flush & (hazard_rs1 | hazard_rs2);

   always_comb begin
      slots_d    = slots_q;
      slots_d[0] = '0;
      if (issue_valid && !stall && !flush) begin
         slots_d[0].valid   = 1'b1;
         slots_d[0].rd      = RegAddrW'(issue_rd);
         slots_d[0].wr      = issue_wr;
         slots_d[0].is_load = issue_is_load;
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
         slots_d[k] = slots_q[k-1];
      end

      inflight_d = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         inflight_d = inflight_d + SW'(slots_d[k].valid);
      end

      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slots_q       <= '0;
         inflight_q    <= '0;
         stall_count_q <= '0;
      end else begin
         slots_q       <= slots_d;
         inflight_q    <= inflight_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign inflight    = inflight_q;
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_scoreboard_fwd.sv
// Scoreboard bench for scoreboard_fwd: expectations queued as stimulus is driven,
// popped and compared against the DUT outputs at the falling edge.
module tb_scoreboard_fwd;

   logic        clk;
   logic        reset;
   logic        issue_valid;
   logic [4:0]  issue_rs1;
   logic [4:0]  issue_rs2;
   logic [4:0]  issue_rd;
   logic        issue_wr;
   logic        issue_is_load;
   logic        flush;
   logic [95:0] stage_data;
   logic        stall;
   logic [1:0]  fwd_sel_rs1;
   logic [1:0]  fwd_sel_rs2;
   logic [31:0] fwd_data_rs1;
   logic [31:0] fwd_data_rs2;
   logic [1:0]  inflight;
   logic [31:0] stall_count;

   scoreboard_fwd u_dut (
      .clk           (clk),
      .reset         (reset),
      .issue_valid   (issue_valid),
      .issue_rs1     (issue_rs1),
      .issue_rs2     (issue_rs2),
      .issue_rd      (issue_rd),
      .issue_wr      (issue_wr),
      .issue_is_load (issue_is_load),
      .flush         (flush),
      .stage_data    (stage_data),
      .stall         (stall),
      .fwd_sel_rs1   (fwd_sel_rs1),
      .fwd_sel_rs2   (fwd_sel_rs2),
      .fwd_data_rs1  (fwd_data_rs1),
      .fwd_data_rs2  (fwd_data_rs2),
      .inflight      (inflight),
      .stall_count   (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed vector: {stall, sel1, sel2, data1, data2, inflight, stall_count}
   logic [102:0] obs;
   assign obs = {stall, fwd_sel_rs1, fwd_sel_rs2, fwd_data_rs1, fwd_data_rs2, inflight,
                 stall_count};

   typedef struct {
      string        name;
      logic [102:0] val;
      logic [102:0] mask;
   } exp_t;

   exp_t         sb_q[$];
   int           checks = 0;
   int           errors = 0;
   logic [102:0] m_all, m_no1, m_no2, m_nosel;

   function automatic logic [102:0] pk(input logic st, input logic [1:0] s1,
                                       input logic [1:0] s2, input logic [31:0] d1,
                                       input logic [31:0] d2, input logic [1:0] inf,
                                       input logic [31:0] cnt);
      return {st, s1, s2, d1, d2, inf, cnt};
   endfunction

   task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic wr, input logic ld,
                        input logic fl);
      issue_valid   = v;
      issue_rs1     = rs1;
      issue_rs2     = rs2;
      issue_rd      = rd;
      issue_wr      = wr;
      issue_is_load = ld;
      flush         = fl;
   endtask

   task automatic set_sd(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
      stage_data = {s2, s1, s0};
   endtask

   task automatic push(input string n, input logic [102:0] v, input logic [102:0] m);
      exp_t e;
      e.name = n;
      e.val  = v;
      e.mask = m;
      sb_q.push_back(e);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      drive(0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      next_cycle();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      exp_t e;
      drive(1, 7, 7, 7, 1, 1, 0);
      set_sd(32'h11, 32'h22, 32'h33);
      #1;
      reset = 1'b0;
      push("reset_outputs", pk(0, 0, 0, 0, 0, 0, 0), m_all);
      #1;
      e = sb_q.pop_front();
      checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
         errors++;
         $display("FAIL %s got %h want %h mask %h", e.name, obs, e.val, e.mask);
      end
      next_cycle();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_forward_alu();
      exp_t e;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         case (i)
            0: begin
               drive(1, 0, 0, 5, 1, 0, 0);
               set_sd(32'h1, 32'h2, 32'h3);
               push("alu_first_issue", pk(0, 0, 0, 0, 0, 0, 0), m_all);
            end
            1: begin
               drive(1, 5, 0, 6, 1, 0, 0);
               set_sd(32'h1234, 32'h2, 32'h3);
               push("alu_fwd_slot0", pk(0, 1, 0, 32'h1234, 0, 1, 0), m_all);
            end
            default: begin
               drive(0, 5, 6, 0, 0, 0, 0);
               set_sd(32'h66, 32'h55, 32'h3);
               push("alu_fwd_two_slots", pk(0, 2, 1, 32'h55, 32'h66, 2, 0), m_all);
            end
         endcase
         @(negedge clk);
         e = sb_q.pop_front();
         checks++;
         if ((obs & e.mask) !== (e.val & e.mask)) begin
            errors++;
            $display("FAIL %s got %h want %h mask %h", e.name, obs, e.val, e.mask);
         end
         next_cycle();
      end
   endtask

   task automatic test_load_use();
      exp_t e;
      apply_reset();
      for (int i = 0; i < 7; i++) begin
         case (i)
            0: begin
               drive(1, 0, 0, 7, 1, 1, 0);
               set_sd(32'h1, 32'h7777, 32'h3);
               push("lu_issue_load", pk(0, 0, 0, 0, 0, 0, 0), m_all);
            end
            1: begin
               drive(1, 7, 7, 8, 1, 0, 0);
               push("lu_stall", pk(1, 0, 0, 0, 0, 1, 0), m_nosel);
            end
            2: push("lu_release_fwd", pk(0, 2, 2, 32'h7777, 32'h7777, 1, 1), m_all);
            3: begin
               drive(0, 7, 8, 0, 0, 0, 0);
               set_sd(32'h80, 32'h81, 32'h82);
               push("lu_after_bubble", pk(0, 3, 1, 32'h82, 32'h80, 2, 1), m_all);
            end
            4: begin
               drive(1, 0, 0, 1, 1, 1, 0);
               push("lu_second_load", pk(0, 0, 0, 0, 0, 1, 1), m_all);
            end
            5: begin
               drive(1, 0, 1, 2, 1, 0, 0);
               push("lu_rs2_stall", pk(1, 0, 0, 0, 0, 2, 1), m_no2);
            end
            default: begin
               drive(0, 0, 0, 0, 0, 0, 0);
               push("lu_count_two", pk(0, 0, 0, 0, 0, 1, 2), m_all);
            end
         endcase
         @(negedge clk);
         e = sb_q.pop_front();
         checks++;
         if ((obs & e.mask) !== (e.val & e.mask)) begin
            errors++;
            $display("FAIL %s got %h want %h mask %h", e.name, obs, e.val, e.mask);
         end
         next_cycle();
      end
   endtask

   task automatic test_x0();
      exp_t e;
      apply_reset();
      for (int i = 0; i < 2; i++) begin
         if (i == 0) begin
            drive(1, 0, 0, 0, 1, 0, 0);
            set_sd(32'h11, 32'h22, 32'h33);
            push("x0_write", pk(0, 0, 0, 0, 0, 0, 0), m_all);
         end else begin
            drive(1, 0, 0, 1, 1, 0, 0);
            push("x0_read_no_fwd", pk(0, 0, 0, 0, 0, 1, 0), m_all);
         end
         @(negedge clk);
         e = sb_q.pop_front();
         checks++;
         if ((obs & e.mask) !== (e.val & e.mask)) begin
            errors++;
            $display("FAIL %s got %h want %h mask %h", e.name, obs, e.val, e.mask);
         end
         next_cycle();
      end
   endtask

   task automatic test_youngest();
      exp_t e;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         case (i)
            0: begin
               drive(1, 0, 0, 9, 1, 0, 0);
               set_sd(32'h1, 32'h2, 32'h3);
               push("yw_first", pk(0, 0, 0, 0, 0, 0, 0), m_all);
            end
            1: push("yw_second", pk(0, 0, 0, 0, 0, 1, 0), m_all);
            default: begin
               drive(1, 9, 9, 10, 1, 0, 0);
               set_sd(32'hBBBB, 32'hAAAA, 32'hCCCC);
               push("yw_youngest_wins", pk(0, 1, 1, 32'hBBBB, 32'hBBBB, 2, 0), m_all);
            end
         endcase
         @(negedge clk);
         e = sb_q.pop_front();
         checks++;
         if ((obs & e.mask) !== (e.val & e.mask)) begin
            errors++;
            $display("FAIL %s got %h want %h mask %h", e.name, obs, e.val, e.mask);
         end
         next_cycle();
      end
   endtask

   task automatic test_flush();
      exp_t e;
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: begin
               drive(1, 0, 0, 7, 1, 1, 0);
               set_sd(32'h1, 32'h7777, 32'h3);
               push("fl_issue_load", pk(0, 0, 0, 0, 0, 0, 0), m_all);
            end
            1: begin
               drive(1, 7, 0, 8, 1, 0, 1);
               push("fl_hazard_flushed", pk(0, 0, 0, 0, 0, 1, 0), m_no1);
            end
            2: begin
               drive(1, 7, 0, 8, 1, 0, 1);
               push("fl_fwd_flushed", pk(0, 2, 0, 32'h7777, 0, 1, 0), m_all);
            end
            3: begin
               drive(0, 0, 0, 0, 0, 0, 0);
               push("fl_no_entry", pk(0, 0, 0, 0, 0, 1, 0), m_all);
            end
            default: push("fl_drained", pk(0, 0, 0, 0, 0, 0, 0), m_all);
         endcase
         @(negedge clk);
         e = sb_q.pop_front();
         checks++;
         if ((obs & e.mask) !== (e.val & e.mask)) begin
            errors++;
            $display("FAIL %s got %h want %h mask %h", e.name, obs, e.val, e.mask);
         end
         next_cycle();
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      apply_reset();
      set_sd(32'h31, 32'h32, 32'h33);
      for (int i = 0; i < 7; i++) begin
         case (i)
            0: begin
               drive(1, 0, 0, 3, 1, 0, 0);
               push("bb_w1", pk(0, 0, 0, 0, 0, 0, 0), m_all);
            end
            1: push("bb_w2", pk(0, 0, 0, 0, 0, 1, 0), m_all);
            2: begin
               drive(1, 0, 0, 3, 1, 1, 0);
               push("bb_w3_load", pk(0, 0, 0, 0, 0, 2, 0), m_all);
            end
            3: begin
               drive(1, 0, 3, 4, 1, 0, 0);
               push("bb_stall_before_reset", pk(1, 0, 0, 0, 0, 3, 0), m_no2);
            end
            4: begin
               // Assert reset mid-stall, away from any clock edge.
               reset = 1'b0;
               #1;
               push("bb_reset_immediate", pk(0, 0, 0, 0, 0, 0, 0), m_all);
            end
            5: begin
               reset = 1'b1;
               drive(1, 3, 3, 5, 1, 0, 0);
               push("bb_first_after_reset", pk(0, 0, 0, 0, 0, 0, 0), m_all);
            end
            default: begin
               drive(0, 0, 0, 0, 0, 0, 0);
               push("bb_accepted", pk(0, 0, 0, 0, 0, 1, 0), m_all);
            end
         endcase
         if (i != 4) @(negedge clk);
         e = sb_q.pop_front();
         checks++;
         if ((obs & e.mask) !== (e.val & e.mask)) begin
            errors++;
            $display("FAIL %s got %h want %h mask %h", e.name, obs, e.val, e.mask);
         end
         if (i != 3) next_cycle();
      end
   endtask

   initial begin
      m_all   = '1;
      m_no1   = ~pk(0, 2'd3, 0, 32'hFFFF_FFFF, 0, 0, 0);
      m_no2   = ~pk(0, 0, 2'd3, 0, 32'hFFFF_FFFF, 0, 0);
      m_nosel = m_no1 & m_no2;
      reset   = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      set_sd(0, 0, 0);
      #2;
      test_reset();
      test_forward_alu();
      test_load_use();
      test_x0();
      test_youngest();
      test_flush();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
